lsu_memctrl: RTL

Load/store memory access controller in the MEM stage, directly upstream of the load-data sign/zero extender. It accepts one load or store per transaction from EX and runs a req/gnt/rvalid handshake with the data memory. Store data is lane-aligned with byte enables. Load data is right-aligned and presented with funct3 and a one-cycle valid (trueop), so the extender can select byte/half/word.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_storealign.sv | 31 +++
 rtl/lsu_memctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, LSU FSM states and alignment helpers shared by the MEM-stage LSU.
package lsu_pkg;

  localparam logic [7:0] F3_B  = 8'd0;
  localparam logic [7:0] F3_H  = 8'd1;
  localparam logic [7:0] F3_W  = 8'd2;
  localparam logic [7:0] F3_BU = 8'd4;
  localparam logic [7:0] F3_HU = 8'd5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  function automatic logic is_half(input logic [7:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(
    input logic [7:0] f3,
    input logic [1:0] lo
  );
    return (is_half(f3) && lo[0]) ||
           ((f3 == F3_W) && (lo != 2'b00));
  endfunction

  // Natural alignment: halves drop bit 0, words drop both bits.
  function automatic logic [1:0] align_lane(
    input logic [7:0] f3,
    input logic [1:0] lo
  );
    if (is_half(f3))  return {lo[1], 1'b0};
    if (f3 == F3_W)   return 2'b00;
    return lo;
  endfunction

endpackage

// File: rtl/lsu_storealign.sv
// lsu_storealign: byte enables and lane-replicated write data for a store.
module lsu_storealign
  import lsu_pkg::*;
(
  input  logic [7:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] storedata,
  output logic [3:0]  ben,
  output logic [31:0] wdata
);

  always_comb begin
    ben   = 4'b1111;
    wdata = storedata;
    unique case (1'b1)
      (funct3 == F3_B): begin
        ben   = 4'(4'b0001 << lane);
        wdata = {4{storedata[7:0]}};
      end
      (funct3 == F3_H): begin
        ben   = 4'(4'b0011 << lane);
        wdata = {2{storedata[15:0]}};
      end
      default: begin
        ben   = 4'b1111;
        wdata = storedata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_memctrl.sv
// lsu_memctrl: MEM-stage load/store controller (req/gnt/rvalid data bus).
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of realigning.
module lsu_memctrl
  import lsu_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          reqvalid,
  output logic          reqready,
  input  logic          isload,
  input  logic          isstore,
  input  logic [7:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] storedata,
  output logic          memreq,
  output logic          memwe,
  output logic [AW-1:0] memaddr,
  output logic [DW-1:0] memwdata,
  output logic [3:0]    memben,
  input  logic          memgnt,
  input  logic          memrvalid,
  input  logic [DW-1:0] memrdata,
  output logic          trueop,
  output logic [7:0]    funct3out,
  output logic [DW-1:0] datatowrite,
  output logic          storedone,
  output logic          stall,
  output logic          misalign,
  output logic          buserr
);

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [1:0]  lane, lane_al;
  logic [7:0]  cnt;
  logic        go, dual, mis;
  logic [3:0]  ben_c;
  logic [31:0] wdata_c;

  assign dual = reqvalid & isload & isstore;
  assign go   = reqvalid & (isload ^ isstore);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis     = go & misaligned(funct3, addr[1:0]);
  assign lane_al = addr[1:0];
`else
  assign mis     = 1'b0;
  assign lane_al = align_lane(funct3, addr[1:0]);
`endif

  assign reqready = (state == IDLE);
  assign stall    = (state != IDLE);

  lsu_storealign u_align (
    .funct3    (funct3),
    .lane      (lane_al),
    .storedata (storedata),
    .ben       (ben_c),
    .wdata     (wdata_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go && !mis) state_nx = REQ;
      REQ:  if (memgnt) state_nx = memwe ? IDLE : WAIT;
      WAIT: if (memrvalid || cnt == TLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      memreq      <= 1'b0;
      memwe       <= 1'b0;
      memaddr     <= '0;
      memwdata    <= '0;
      memben      <= 4'b0000;
      trueop      <= 1'b0;
      storedone   <= 1'b0;
      misalign    <= 1'b0;
      buserr      <= 1'b0;
      datatowrite <= '0;
      funct3out   <= 8'd0;
      lane        <= 2'b00;
      cnt         <= 8'd0;
    end else begin
      trueop    <= 1'b0;
      storedone <= 1'b0;
      misalign  <= 1'b0;
      buserr    <= 1'b0;
      memreq    <= (state_nx == REQ);
      unique case (state)
        IDLE: begin
          if (dual) begin
            buserr <= 1'b1;
          end else if (go) begin
            funct3out <= funct3;
            lane      <= lane_al;
            if (mis) begin
              misalign <= 1'b1;
            end else begin
              memaddr  <= {addr[AW-1:2], 2'b00};
              memwe    <= isstore;
              memben   <= ben_c;
              memwdata <= wdata_c;
            end
          end
        end
        REQ: begin
          cnt <= 8'd0;
          if (memgnt && memwe) storedone <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (memrvalid) begin
            datatowrite <= memrdata >> {lane, 3'b000};
            trueop      <= 1'b1;
          end else if (cnt == TLAST) begin
            buserr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
